tx_frame_sequencer: RTL and testbench

//  Frames the byte stream feeding the packer/spreader chain of the QPSK modulator.
//  On a start command it emits, in order: preamble bytes, sync word, 16-bit length,

---
 rtl/tx_frame_sequencer.sv | 168 ++++++++++++++++
 tb/tb_tx_frame_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_sequencer.sv
// Frame sequencer between byte source and packer: preamble, sync, length,
// payload, XOR checksum, then idle gap.
// Ports: i_clk, i_reset (async high), i_start/i_payload_len (frame request),
//   o_busy/o_done (status), i_data/i_valid_input/o_ready (source side),
//   o_data/o_valid/i_ready_output (packer side, registered stream).
module tx_frame_sequencer #(
  parameter int              DATA_W        = 8,
  parameter int              LEN_W         = 12,
  parameter int              PREAMBLE_LEN  = 4,
  parameter logic [7:0]      PREAMBLE_BYTE = 8'h55,
  parameter logic [31:0]     SYNC_WORD     = 32'h1ACFFC1D,
  parameter int              GAP_LEN       = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_payload_len,
  output logic              o_busy,
  output logic              o_done,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid_input,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready_output
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SYNC,
    S_LEN,
    S_PAY,
    S_CSUM,
    S_GAP
  } state_t;

  localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_LEN - 1);

  state_t              state;
  logic [15:0]         cnt;
  logic [15:0]         len;
  logic [15:0]         remaining;
  logic [DATA_W-1:0]   csum;
  logic                load;
  logic                accept;
  logic [7:0]          sync_byte;
  logic [7:0]          len_byte;

  // Output register may take a new byte when empty or draining this cycle.
  assign load   = !o_valid || i_ready_output;
  assign o_ready = (state == S_PAY) && load && (remaining != 16'd0);
  assign accept = o_ready && i_valid_input;
  assign o_busy = (state != S_IDLE);
  // Last gap cycle; still a busy cycle, IDLE follows.
  assign o_done = (state == S_GAP) && !o_valid && (cnt == GAP_LAST);

  always_comb begin
    sync_byte = SYNC_WORD[31:24];
    unique case (cnt[1:0])
      2'd0: sync_byte = SYNC_WORD[31:24];
      2'd1: sync_byte = SYNC_WORD[23:16];
      2'd2: sync_byte = SYNC_WORD[15:8];
      2'd3: sync_byte = SYNC_WORD[7:0];
    endcase
  end

  assign len_byte = cnt[0] ? len[7:0] : len[15:8];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      len       <= '0;
      remaining <= '0;
      csum      <= '0;
      o_data    <= '0;
      o_valid   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            len       <= 16'(i_payload_len);
            remaining <= 16'(i_payload_len);
            csum      <= '0;
            cnt       <= '0;
            state     <= S_PRE;
          end
        end
        S_PRE: begin
          if (load) begin
            o_data  <= PREAMBLE_BYTE;
            o_valid <= 1'b1;
            if (cnt == PRE_LAST) begin
              cnt   <= '0;
              state <= S_SYNC;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        S_SYNC: begin
          if (load) begin
            o_data  <= sync_byte;
            o_valid <= 1'b1;
            if (cnt == 16'd3) begin
              cnt   <= '0;
              state <= S_LEN;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        S_LEN: begin
          if (load) begin
            o_data  <= len_byte;
            o_valid <= 1'b1;
            if (cnt == 16'd1) begin
              cnt   <= '0;
              state <= (len != 16'd0) ? S_PAY : S_CSUM;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        S_PAY: begin
          if (accept) begin
            o_data    <= i_data;
            o_valid   <= 1'b1;
            csum      <= csum ^ i_data;
            remaining <= remaining - 16'd1;
            if (remaining == 16'd1) begin
              state <= S_CSUM;
            end
          end else if (load) begin
            // Source stalled: let the current byte drain, no filler.
            o_valid <= 1'b0;
          end
        end
        S_CSUM: begin
          if (load) begin
            o_data  <= csum;
            o_valid <= 1'b1;
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (o_valid) begin
            if (i_ready_output) begin
              o_valid <= 1'b0;
            end
          end else if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state   <= S_IDLE;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Bench for tx_frame_sequencer: vector table of frames plus
// hand-written reset and long-frame sequences.
module tb_tx_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [11:0] plen;
  logic       busy;
  logic       done;
  logic [7:0] din;
  logic       vin;
  logic       rdy_o;
  logic [7:0] dout;
  logic       vld_o;
  logic       rout;

  always #5 clk = ~clk;

  tx_frame_sequencer dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_start        (start),
    .i_payload_len  (plen),
    .o_busy         (busy),
    .o_done         (done),
    .i_data         (din),
    .i_valid_input  (vin),
    .o_ready        (rdy_o),
    .o_data         (dout),
    .o_valid        (vld_o),
    .i_ready_output (rout)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int          len;
    logic [31:0] pay;
    int          bp;
    int          stall_at;
    int          stall_len;
    int          inj;
    logic [7:0]  csum;
    int          nbytes;
    int          bubbles;
  } vec_t;

  logic [7:0] pay[$];
  logic [7:0] outq[$];
  int         xcyc[$];
  int         ready_cnt;
  int         done_cnt;
  int         done_cyc;
  int         stall_bad;
  int         busy_bad;
  bit         timeout;

  task automatic run_frame(input int len, input int bp, input int stall_at,
                           input int stall_len, input int inj,
                           input int budget);
    int         idx = 0;
    int         cyc = 0;
    int         sleft = stall_len;
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic [7:0] pd = 8'h00;
    bit         pdone = 0;
    bit         fin = 0;
    outq.delete();
    xcyc.delete();
    ready_cnt = 0;
    done_cnt  = 0;
    done_cyc  = -1;
    stall_bad = 0;
    busy_bad  = 0;
    timeout   = 0;
    while (!fin) begin
      @(negedge clk);
      start = (cyc == 0) || (cyc == inj);
      plen  = (cyc == inj) ? 12'hFFF : 12'(len);
      case (bp)
        0:       rout = 1'b1;
        1:       rout = (cyc % 2) == 0;
        default: rout = $urandom_range(0, 3) != 0;
      endcase
      if (idx == stall_at && sleft > 0) begin
        vin = 1'b0;
        sleft--;
      end else begin
        vin = 1'b1;
      end
      din = (idx < pay.size()) ? pay[idx] : 8'hEE;
      #1;
      if (pv && !pr && (vld_o !== 1'b1 || dout !== pd)) stall_bad++;
      if (vld_o && rout) begin
        outq.push_back(dout);
        xcyc.push_back(cyc);
      end
      if (rdy_o) ready_cnt++;
      if (rdy_o && vin) idx++;
      if (pdone) begin
        if (busy !== 1'b0) busy_bad++;
        fin = 1;
      end else if (cyc > 0 && busy !== 1'b1) begin
        busy_bad++;
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        pdone = 1;
      end
      pv = vld_o;
      pr = rout;
      pd = dout;
      cyc++;
      if (cyc >= budget && !fin) begin
        timeout = 1;
        fin = 1;
      end
    end
    start = 1'b0;
    vin   = 1'b0;
    rout  = 1'b1;
  endtask

  task automatic check_frame(input string nm, input int len,
                             input logic [7:0] csum, input int nbytes,
                             input int bubbles);
    logic [7:0] exp[$];
    logic [15:0] l16;
    int nbm = 0;
    int first = -1;
    l16 = 16'(len);
    repeat (4) exp.push_back(8'h55);
    exp.push_back(8'h1A);
    exp.push_back(8'hCF);
    exp.push_back(8'hFC);
    exp.push_back(8'h1D);
    exp.push_back(l16[15:8]);
    exp.push_back(l16[7:0]);
    foreach (pay[i]) exp.push_back(pay[i]);
    exp.push_back(csum);
    chk({nm, " timeout"}, 32'(timeout), 0);
    chk({nm, " nbytes"}, outq.size(), nbytes);
    for (int i = 0; i < outq.size() && i < exp.size(); i++) begin
      if (outq[i] !== exp[i]) begin
        nbm++;
        if (first < 0) first = i;
      end
    end
    chk($sformatf("%s bytes(first bad %0d)", nm, first), nbm, 0);
    if (outq.size() > 0) begin
      chk({nm, " csum"}, 32'(outq[outq.size()-1]), 32'(csum));
      chk({nm, " gap"}, done_cyc - xcyc[xcyc.size()-1], 16);
      if (bubbles >= 0)
        chk({nm, " bubbles"},
            xcyc[xcyc.size()-1] - xcyc[0] + 1 - outq.size(), bubbles);
    end
    chk({nm, " done_cnt"}, done_cnt, 1);
    chk({nm, " stall_hold"}, stall_bad, 0);
    chk({nm, " busy"}, busy_bad, 0);
    if (len == 0) chk({nm, " ready_cnt"}, ready_cnt, 0);
  endtask

  vec_t vecs[5];

  initial begin
    logic [7:0] x;
    bit found;
    vecs[0] = '{3, 32'h11223300, 0, -1, 0, -1, 8'h00, 14, 0};
    vecs[1] = '{0, 32'h00000000, 0, -1, 0, -1, 8'h00, 11, 0};
    vecs[2] = '{4, 32'hA55AFF00, 1, -1, 0, -1, 8'h00, 15, -1};
    vecs[3] = '{4, 32'h01020408, 0, 2, 5, 8, 8'h0F, 15, 5};
    vecs[4] = '{1, 32'h7E000000, 2, -1, 0, -1, 8'h7E, 12, -1};

    rst = 1'b1;
    start = 1'b0;
    plen = '0;
    din = '0;
    vin = 1'b0;
    rout = 1'b1;
    #12;
    chk("rst o_valid", 32'(vld_o), 0);
    chk("rst o_data", 32'(dout), 0);
    chk("rst o_busy", 32'(busy), 0);
    chk("rst o_done", 32'(done), 0);
    chk("rst o_ready", 32'(rdy_o), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      pay.delete();
      for (int b = 0; b < vecs[v].len; b++)
        pay.push_back(vecs[v].pay[31-8*b -: 8]);
      run_frame(vecs[v].len, vecs[v].bp, vecs[v].stall_at,
                vecs[v].stall_len, vecs[v].inj, 200);
      check_frame($sformatf("vec%0d", v), vecs[v].len, vecs[v].csum,
                  vecs[v].nbytes, vecs[v].bubbles);
    end

    // Reset while the second sync byte is on the output.
    pay.delete();
    pay.push_back(8'hC3);
    pay.push_back(8'h3C);
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      start = (c == 0);
      plen = 12'd2;
      rout = 1'b1;
      vin = 1'b1;
      din = 8'hC3;
      #1;
      if (vld_o === 1'b1 && dout === 8'hCF) found = 1;
    end
    chk("rst_mid found", 32'(found), 1);
    start = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mid o_valid", 32'(vld_o), 0);
    chk("rst_mid o_data", 32'(dout), 0);
    chk("rst_mid o_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    run_frame(2, 0, -1, 0, -1, 200);
    check_frame("after_rst", 2, 8'hFF, 13, 0);

    // Maximum length with random payload and backpressure.
    pay.delete();
    x = 8'h00;
    for (int b = 0; b < 4095; b++) begin
      pay.push_back(8'($urandom_range(0, 255)));
      x = x ^ pay[b];
    end
    run_frame(4095, 2, -1, 0, -1, 20000);
    check_frame("maxlen", 4095, x, 4106, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
